// File: rtl/ram_pkg.sv
// Shared types and constants for the clearable synchronous RAM.
// Parity storage is enabled by defining RAM_SYNC_CLR_PARITY_EN.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

`ifdef RAM_SYNC_CLR_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks clr_addr over every implemented word after reset
// or on request, then raises ready until the next clear.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req_i,
  output logic              ready_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  // Terminal compare instead of wrap so DEPTH == 2**ADDR_W also ends cleanly.
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_addr_q == LAST) begin
            state_q    <= READY;
            clr_addr_q <= '0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        READY: begin
          if (clear_req_i) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
          end
        end
        default: begin
          state_q    <= CLEAR;
          clr_addr_q <= '0;
        end
      endcase
    end
  end

  assign ready_o    = (state_q == READY);
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = clr_addr_q;

endmodule

// File: rtl/ram_sync_clr.sv
// Parametrised single-port RAM with registered read, write-first bypass and a
// built-in clear sequencer. Define RAM_SYNC_CLR_PARITY_EN to store even parity.
module ram_sync_clr
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              rd_en,
  input  logic              clear_req,
  output logic [DATA_W-1:0] out,
  output logic              ready,
  output logic              parity_err
);

  localparam int MEM_W = DATA_W + PAR_W;

  logic              seq_ready;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_clr_seq #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req_i(clear_req),
    .ready_o    (seq_ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic              in_range;
  logic              user_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic              rd_perr;
  logic [DATA_W-1:0] out_q;
  logic              perr_q;

  assign in_range = (32'(address) < DEPTH);
  assign user_we  = seq_ready & load & in_range;
  assign wr_addr  = clr_we ? clr_addr : address;
  assign rd_word  = mem_q[address];

`ifdef RAM_SYNC_CLR_PARITY_EN
  assign wr_word = clr_we ? '0 : {^in, in};
  assign rd_perr = rd_word[DATA_W] ^ (^rd_word[DATA_W-1:0]);
`else
  assign wr_word = clr_we ? '0 : in;
  assign rd_perr = 1'b0;
`endif

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (clr_we || user_we) mem_q[wr_addr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      perr_q <= 1'b0;
    end else if (seq_ready && rd_en) begin
      if (!in_range) begin
        out_q  <= '0;
        perr_q <= 1'b0;
      end else if (load) begin
        out_q  <= in;
        perr_q <= 1'b0;
      end else begin
        out_q  <= rd_word[DATA_W-1:0];
        perr_q <= rd_perr;
      end
    end
  end

  assign out        = out_q;
  assign ready      = seq_ready;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed bench for ram_sync_clr: a DEPTH=16 and a DEPTH=12 instance share stimulus.
module tb_ram_sync_clr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  addr = '0;
  logic        load = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_req = 1'b0;
  logic [15:0] o16, o12;
  logic        rdy16, rdy12, pe16, pe12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_sync_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in(din), .address(addr), .load(load),
    .rd_en(rd_en), .clear_req(clr_req), .out(o16), .ready(rdy16), .parity_err(pe16)
  );

  ram_sync_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(12)) u12 (
    .clk(clk), .rst_n(rst_n), .in(din), .address(addr), .load(load),
    .rd_en(rd_en), .clear_req(clr_req), .out(o12), .ready(rdy12), .parity_err(pe12)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic rd, input logic [3:0] a, input logic [15:0] d);
    load  = ld;
    rd_en = rd;
    addr  = a;
    din   = d;
  endtask

  initial begin
    int n;
    #1;
    chk("rst_out", 32'(o16), 0);
    chk("rst_ready", 32'(rdy16), 0);
    chk("rst_perr", 32'(pe16), 0);
    step();
    step();
    rst_n = 1'b1;

    // ready must rise exactly on the DEPTH-th edge after release
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("rel_ready16", 32'(rdy16), (k == 16) ? 1 : 0);
      if (k >= 11) chk("rel_ready12", 32'(rdy12), (k >= 12) ? 1 : 0);
    end

    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b1, 4'(a), 16'h0);
      step();
      chk("init_zero", 32'(o16), 0);
    end

    // write, then read next cycle, then hold
    drive(1'b1, 1'b0, 4'd5, 16'hBEEF); step();
    drive(1'b0, 1'b1, 4'd5, 16'h0);    step();
    chk("rd_beef", 32'(o16), 32'hBEEF);
    drive(1'b0, 1'b0, 4'd7, 16'h0);    step();
    chk("hold_beef_a", 32'(o16), 32'hBEEF);
    drive(1'b0, 1'b0, 4'd0, 16'h0);    step();
    chk("hold_beef_b", 32'(o16), 32'hBEEF);

    // write-first bypass
    drive(1'b1, 1'b0, 4'd3, 16'hAAAA); step();
    drive(1'b0, 1'b1, 4'd3, 16'h0);    step();
    chk("rd_aaaa", 32'(o16), 32'hAAAA);
    drive(1'b1, 1'b1, 4'd3, 16'h1234); step();
    chk("wf_out", 32'(o16), 32'h1234);
    chk("wf_perr", 32'(pe16), 0);
    drive(1'b0, 1'b1, 4'd3, 16'h0);    step();
    chk("wf_reread", 32'(o16), 32'h1234);

    // out-of-range on the DEPTH=12 instance
    drive(1'b1, 1'b0, 4'd13, 16'h5555); step();
    drive(1'b0, 1'b1, 4'd5, 16'h0);     step();
    chk("u12_rd5", 32'(o12), 32'hBEEF);
    drive(1'b0, 1'b1, 4'd13, 16'h0);    step();
    chk("u12_rd13", 32'(o12), 0);
    chk("u12_rd13_perr", 32'(pe12), 0);
    chk("u16_rd13", 32'(o16), 32'h5555);
    drive(1'b0, 1'b1, 4'd12, 16'h0);    step();
    chk("u12_rd12", 32'(o12), 0);
    drive(1'b0, 1'b1, 4'd1, 16'h0);     step();
    chk("u12_rd1", 32'(o12), 0);

    // fill, then clear with a coincident write-first access
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 1'b0, 4'(a), 16'hA000 + 16'(a));
      step();
    end
    drive(1'b0, 1'b1, 4'd9, 16'h0); step();
    chk("fill_rd9", 32'(o16), 32'hA009);
    drive(1'b1, 1'b1, 4'd2, 16'h7777);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("clr_same_cycle_out", 32'(o16), 32'h7777);
    chk("clr_ready0", 32'(rdy16), 0);
    drive(1'b1, 1'b1, 4'd4, 16'hFFFF);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("clr_ready", 32'(rdy16), (k == 16) ? 1 : 0);
    end
    chk("clr_out_hold", 32'(o16), 32'h7777);
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b1, 4'(a), 16'h0);
      step();
      chk("post_clr_zero", 32'(o16), 0);
    end

    // reset asserted partway through a clear
    drive(1'b1, 1'b0, 4'd6, 16'h1357); step();
    drive(1'b0, 1'b1, 4'd6, 16'h0);    step();
    chk("rd_1357", 32'(o16), 32'h1357);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    while (u16.u_seq.clr_addr_o != 4'd7 && n < 40) begin
      step();
      n++;
    end
    chk("midclr_reached7", 32'(n < 40), 1);
    rst_n = 1'b0;
    #1;
    chk("midclr_rst_out", 32'(o16), 0);
    chk("midclr_rst_ready", 32'(rdy16), 0);
    chk("midclr_rst_addr", 32'(u16.u_seq.clr_addr_o), 0);
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("midclr_ready", 32'(rdy16), (k == 16) ? 1 : 0);
    end

    // parity
    drive(1'b1, 1'b0, 4'd2, 16'h00F0); step();
    drive(1'b1, 1'b0, 4'd4, 16'h0F0F); step();
    drive(1'b0, 1'b0, 4'd0, 16'h0);
`ifdef RAM_SYNC_CLR_PARITY_EN
    u16.mem_q[2] = u16.mem_q[2] ^ 17'h00001;
    drive(1'b0, 1'b1, 4'd2, 16'h0); step();
    chk("par_out2", 32'(o16), 32'h00F1);
    chk("par_err2", 32'(pe16), 1);
`else
    drive(1'b0, 1'b1, 4'd2, 16'h0); step();
    chk("par_out2", 32'(o16), 32'h00F0);
    chk("par_err2", 32'(pe16), 0);
`endif
    drive(1'b0, 1'b1, 4'd4, 16'h0); step();
    chk("par_out4", 32'(o16), 32'h0F0F);
    chk("par_err4", 32'(pe16), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
